// File: rtl/pc_pkg.sv
// Operation encoding shared by the PC sequencer and instruction decode.
package pc_pkg;

  localparam int unsigned PC_OP_W = 3;

  typedef enum logic [PC_OP_W-1:0] {
    PC_OP_NEXT = 3'd0,
    PC_OP_JUMP = 3'd1,
    PC_OP_BREL = 3'd2,
    PC_OP_CALL = 3'd3,
    PC_OP_RET  = 3'd4
  } pc_op_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses; only the occupancy pointer is reset, storage is free-running.
module return_stack #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  push_data,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]     cnt;

  assign full  = (cnt == DW'(STACK_DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;

  // Top of stack is entry depth-1, read combinationally so RET needs no extra cycle.
  assign top = mem[IW'(cnt - DW'(1))];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) begin
      mem[IW'(cnt)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: next-PC select, return-address stack and sticky stack error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  logic [PC_OP_W-1:0]               op_i,
  input  logic                             cond_i,
  input  logic [ADDR_W-1:0]                target_i,
  input  logic [ADDR_W-1:0]                offset_i,
  input  logic                             clear_err_i,
  output logic [ADDR_W-1:0]                pc_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);

  logic [ADDR_W-1:0] pc_q, pc_nxt, pc_inc, stk_top;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic              ovf_set, unf_set, ovf_q, unf_q;

  assign pc_inc = pc_q + ADDR_W'(1);

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .depth     (depth_o),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    pc_nxt   = pc_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (!stall_i) begin
      pc_nxt = pc_inc;
      case (pc_op_e'(op_i))
        PC_OP_JUMP: if (cond_i) pc_nxt = target_i;
        PC_OP_BREL: if (cond_i) pc_nxt = pc_q + offset_i;
        PC_OP_CALL: begin
          // A CALL on a full stack degrades to a plain increment.
          if (stk_full) begin
            ovf_set = 1'b1;
          end else begin
            stk_push = 1'b1;
            pc_nxt   = target_i;
          end
        end
        PC_OP_RET: begin
          if (stk_empty) begin
            unf_set = 1'b1;
          end else begin
            stk_pop = 1'b1;
            pc_nxt  = stk_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      ovf_q <= ovf_set | (ovf_q & ~clear_err_i);
      unf_q <= unf_set | (unf_q & ~clear_err_i);
    end
  end

  assign pc_o        = pc_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test-plan steps followed by random operations, checked against a queue-based model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RVEC  = 8'h10;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       stall_i;
  logic [2:0] op_i;
  logic       cond_i;
  logic [7:0] target_i;
  logic [7:0] offset_i;
  logic       clear_err_i;
  logic [7:0] pc_o;
  logic [2:0] depth_o;
  logic       overflow_o;
  logic       underflow_o;

  pc_sequencer #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (RVEC)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .op_i        (op_i),
    .cond_i      (cond_i),
    .target_i    (target_i),
    .offset_i    (offset_i),
    .clear_err_i (clear_err_i),
    .pc_o        (pc_o),
    .depth_o     (depth_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk [$];
  logic       m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    {24'd0, pc_o},           {24'd0, m_pc});
    chk({tag, ".depth"}, {29'd0, depth_o},        m_stk.size());
    chk({tag, ".ovf"},   {31'd0, overflow_o},     {31'd0, m_ovf});
    chk({tag, ".unf"},   {31'd0, underflow_o},    {31'd0, m_unf});
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Called just after a rising edge: drive, update the model, cross the edge, check.
  task automatic step(input string tag, input logic st, input logic [2:0] op,
                      input logic c, input logic [7:0] tgt, input logic [7:0] off,
                      input logic clr);
    stall_i = st; op_i = op; cond_i = c; target_i = tgt; offset_i = off; clear_err_i = clr;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (!st) begin
      case (op)
        3'd1: m_pc = c ? tgt : m_pc + 8'd1;
        3'd2: m_pc = c ? m_pc + off : m_pc + 8'd1;
        3'd3: begin
          if (m_stk.size() == DEPTH) begin
            m_ovf = 1'b1;
            m_pc  = m_pc + 8'd1;
          end else begin
            m_stk.push_back(m_pc + 8'd1);
            m_pc = tgt;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = m_pc + 8'd1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        default: m_pc = m_pc + 8'd1;
      endcase
    end
    @(posedge clk_i);
    #1;
    chk_model(tag);
    stall_i = 1'b0; op_i = PC_OP_NEXT; clear_err_i = 1'b0;
  endtask

  // Reset pulse placed between edges; values must appear without a clock.
  task automatic async_reset(input string tag);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk_model(tag);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; op_i = PC_OP_NEXT; cond_i = 1'b0;
    target_i = '0; offset_i = '0; clear_err_i = 1'b0;
    model_reset();
    #2;
    chk_model("reset_initial");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Increment and wrap
    step("next1", 0, PC_OP_NEXT, 0, 8'h00, 8'h00, 0);
    step("next2", 0, PC_OP_NEXT, 0, 8'h00, 8'h00, 0);
    step("next3", 0, PC_OP_NEXT, 0, 8'h00, 8'h00, 0);
    chk("pc_after_3_next", {24'd0, pc_o}, 32'h13);
    step("jump_ff", 0, PC_OP_JUMP, 1, 8'hFF, 8'h00, 0);
    step("wrap", 0, PC_OP_NEXT, 0, 8'h00, 8'h00, 0);
    chk("pc_wrap", {24'd0, pc_o}, 32'h00);

    // Conditional branches
    step("jump_20a", 0, PC_OP_JUMP, 1, 8'h20, 8'h00, 0);
    step("brel_neg", 0, PC_OP_BREL, 1, 8'h00, 8'hFC, 0);
    chk("pc_brel_neg", {24'd0, pc_o}, 32'h1C);
    step("jump_20b", 0, PC_OP_JUMP, 1, 8'h20, 8'h00, 0);
    step("brel_nt", 0, PC_OP_BREL, 0, 8'h00, 8'hFC, 0);
    chk("pc_brel_nt", {24'd0, pc_o}, 32'h21);
    step("jump_nt", 0, PC_OP_JUMP, 0, 8'h55, 8'h00, 0);
    step("jump_80", 0, PC_OP_JUMP, 1, 8'h80, 8'h00, 0);
    chk("pc_jump_80", {24'd0, pc_o}, 32'h80);

    // Nested calls
    step("jump_05", 0, PC_OP_JUMP, 1, 8'h05, 8'h00, 0);
    step("call40", 0, PC_OP_CALL, 0, 8'h40, 8'h00, 0);
    chk("nest_pc0", {24'd0, pc_o}, 32'h40);
    chk("nest_d0", {29'd0, depth_o}, 32'd1);
    step("call60", 0, PC_OP_CALL, 0, 8'h60, 8'h00, 0);
    chk("nest_pc1", {24'd0, pc_o}, 32'h60);
    chk("nest_d1", {29'd0, depth_o}, 32'd2);
    step("ret1", 0, PC_OP_RET, 0, 8'h00, 8'h00, 0);
    chk("nest_pc2", {24'd0, pc_o}, 32'h41);
    chk("nest_d2", {29'd0, depth_o}, 32'd1);
    step("ret2", 0, PC_OP_RET, 0, 8'h00, 8'h00, 0);
    chk("nest_pc3", {24'd0, pc_o}, 32'h06);
    chk("nest_d3", {29'd0, depth_o}, 32'd0);

    // Overflow / underflow / clear
    for (int unsigned i = 0; i < 5; i++)
      step("ovf_call", 0, PC_OP_CALL, 0, 8'h90 + 8'(i * 16), 8'h00, 0);
    chk("ovf_pc", {24'd0, pc_o}, 32'hC1);
    chk("ovf_depth", {29'd0, depth_o}, 32'd4);
    chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
    for (int unsigned i = 0; i < 5; i++)
      step("unf_ret", 0, PC_OP_RET, 0, 8'h00, 8'h00, 0);
    chk("unf_flag", {31'd0, underflow_o}, 32'd1);
    step("clear", 0, PC_OP_NEXT, 0, 8'h00, 8'h00, 1);
    chk("clear_ovf", {31'd0, overflow_o}, 32'd0);
    chk("clear_unf", {31'd0, underflow_o}, 32'd0);

    // Stall with CALL pending
    for (int unsigned i = 0; i < 3; i++)
      step("stall_call", 1, PC_OP_CALL, 0, 8'h33, 8'h00, 0);
    step("unstall_call", 0, PC_OP_CALL, 0, 8'h33, 8'h00, 0);
    chk("stall_push_once", {29'd0, depth_o}, 32'd1);

    // Clear colliding with an overflowing CALL
    for (int unsigned i = 0; i < 3; i++)
      step("fill_call", 0, PC_OP_CALL, 0, 8'hA0, 8'h00, 0);
    step("ovf_clear_call", 0, PC_OP_CALL, 0, 8'hB0, 8'h00, 1);
    chk("set_wins", {31'd0, overflow_o}, 32'd1);

    // Reset mid-call
    async_reset("rst_a");
    step("rc_call1", 0, PC_OP_CALL, 0, 8'h44, 8'h00, 0);
    step("rc_call2", 0, PC_OP_CALL, 0, 8'h48, 8'h00, 0);
    chk("rc_depth2", {29'd0, depth_o}, 32'd2);
    async_reset("rst_mid");
    chk("rc_depth0", {29'd0, depth_o}, 32'd0);
    step("rc_ret", 0, PC_OP_RET, 0, 8'h00, 8'h00, 0);
    chk("rc_unf", {31'd0, underflow_o}, 32'd1);

    // Random operations
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        async_reset("rand_rst");
      end else begin
        step("rand",
             ($urandom_range(7) == 0),
             3'($urandom_range(7)),
             1'($urandom_range(1)),
             8'($urandom),
             8'($urandom),
             ($urandom_range(15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
